jk_drive_sequencer: RTL

JK_DRIVE_SEQUENCER -- requirements
Module: jk_drive_sequencer

---
 rtl/jk_seq_pkg.sv | 33 +++
 rtl/jk_cmd_fifo.sv | 60 ++++++
 rtl/jk_drive_sequencer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/jk_seq_pkg.sv
// Shared types for the JK drive sequencer: op codes, FSM states,
// queued command record and the JK next-state helper.
package jk_seq_pkg;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_RST  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_TOG  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_CHECK
    } state_t;

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] rpt;
    } cmd_t;

    function automatic logic jk_next(input logic [1:0] op,
                                     input logic       q);
        logic r;
        unique case (op)
            OP_HOLD: r = q;
            OP_RST:  r = 1'b0;
            OP_SET:  r = 1'b1;
            default: r = ~q;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Command queue: DEPTH entries of cmd_t, head visible on rd_data.
// Ports: clk, rst_n, push/wr_data, pop/rd_data, full, empty.
module jk_cmd_fifo
    import jk_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  cmd_t wr_data,
    input  logic pop,
    output cmd_t rd_data,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    cmd_t           mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           push_ok;
    logic           pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // Full refuses a push even when a pop happens on the same edge.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/jk_drive_sequencer.sv
// Sequences queued JK commands onto j/k and checks q_fb after each.
// Ports: cmd_valid/ready/op/rpt in, j/k drive out, q_fb in, busy/err/tog_cnt.
module jk_drive_sequencer
    import jk_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [3:0]       cmd_rpt,
    output logic             j,
    output logic             k,
    input  logic             q_fb,
    output logic             busy,
    output logic             err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] tog_cnt
);

    state_t     state_q;
    state_t     state_d;
    logic [1:0] jk_q;
    logic [1:0] jk_d;
    logic [3:0] rem_q;
    logic [3:0] rem_d;
    logic       pop;
    logic       full;
    logic       empty;
    cmd_t       cmd_in;
    cmd_t       head;
    logic       exp_q;
    logic       exp_valid;
    logic       drv;
    logic       mism;

    assign cmd_in    = '{op: cmd_op, rpt: cmd_rpt};
    assign cmd_ready = !full;
    assign busy      = !empty || (state_q != ST_IDLE);
    assign j         = jk_q[1];
    assign k         = jk_q[0];
    assign drv       = (state_q == ST_DRIVE);
    // Before any set/reset the flip-flop state is unknown: skip compare.
    assign mism      = (state_q == ST_CHECK) && exp_valid
                       && (q_fb != exp_q);

    jk_cmd_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (cmd_valid),
        .wr_data (cmd_in),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    always_comb begin
        state_d = state_q;
        jk_d    = jk_q;
        rem_d   = rem_q;
        pop     = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_CHECK: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = ST_DRIVE;
                    jk_d    = head.op;
                    rem_d   = head.rpt;
                end else begin
                    state_d = ST_IDLE;
                    jk_d    = OP_HOLD;
                end
            end
            ST_DRIVE: begin
                if (rem_q == 4'd0) begin
                    state_d = ST_CHECK;
                    jk_d    = OP_HOLD;
                end else begin
                    rem_d   = rem_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                jk_d    = OP_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            jk_q    <= OP_HOLD;
            rem_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            jk_q    <= jk_d;
            rem_q   <= rem_d;
        end
    end

    // Expected-q model follows the same edges the flip-flop samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q     <= 1'b0;
            exp_valid <= 1'b0;
            err       <= 1'b0;
            tog_cnt   <= '0;
        end else begin
            if (drv) begin
                exp_q <= jk_next(jk_q, exp_q);
                if (jk_q == OP_RST || jk_q == OP_SET) begin
                    exp_valid <= 1'b1;
                end
                if (jk_q == OP_TOG) begin
                    tog_cnt <= tog_cnt + CNT_W'(1);
                end
            end else if (mism) begin
                exp_q <= q_fb;
            end
            if (mism) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule
